// File: rtl/spi_bus_arb.sv
// spi_bus_arb: round-robin arbiter that shares one SPI master between N_REQ slaves.
// Each grant drives that slave's select, launches one 16-bit frame, returns the
// MISO data and pulses the requester's ack. It aborts with err if the master
// never reports done.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | all selects high, waiting for any request
// S_SETUP  | selected slave's SS_n low, setup time before SCLK starts
// S_LAUNCH | spi_wrt pulse to the SPI master, timeout counter loaded
// S_BUSY   | frame in flight, waiting for spi_done or timeout
// S_GAP    | all selects high for GAP_CYC clks before the next grant
module spi_bus_arb #(
    parameter int N_REQ   = 5,
    parameter int GAP_CYC = 4,
    parameter int TMO_CYC = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [16*N_REQ-1:0]  i_cmd,
    output logic [N_REQ-1:0]     o_ack,
    output logic                 o_err,
    output logic [15:0]          o_rsp_data,
    output logic                 o_spi_wrt,
    output logic [15:0]          o_spi_cmd,
    input  logic                 i_spi_done,
    input  logic [15:0]          i_spi_rd_data,
    output logic [N_REQ-1:0]     o_ss_n,
    output logic                 o_busy
);

    localparam int SEL_W = (N_REQ > 1)   ? $clog2(N_REQ)   : 1;
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    // Both timers are down-counters; the terminal count is zero.
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_LAUNCH = 3'd2,
        S_BUSY   = 3'd3,
        S_GAP    = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_rr_ptr;
    logic [TMO_W-1:0]    r_tmo_cnt;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic [N_REQ-1:0]    r_ack;
    logic                r_err;
    logic [15:0]         r_rsp_data;
    logic                r_spi_wrt;
    logic [15:0]         r_spi_cmd;
    logic [N_REQ-1:0]    r_ss_n;

    logic                w_found;
    logic [SEL_W-1:0]    w_pick;
    logic [SEL_W-1:0]    w_sel_nxt;
    logic [SEL_W-1:0]    w_rr_nxt;
    logic [TMO_W-1:0]    w_tmo_nxt;
    logic [GAP_W-1:0]    w_gap_nxt;
    logic [N_REQ-1:0]    w_ack_nxt;
    logic                w_err_nxt;
    logic [15:0]         w_rsp_nxt;
    logic                w_wrt_nxt;
    logic [15:0]         w_cmd_nxt;
    logic [N_REQ-1:0]    w_ss_n_nxt;
    logic                w_finish;

    // Index wrap for the round-robin search; avoids a general modulo.
    function automatic int wrap_idx(input int a);
        return (a >= N_REQ) ? (a - N_REQ) : a;
    endfunction

    // Round-robin pick: first asserted request at or above rr_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && i_req[wrap_idx(int'(r_rr_ptr) + k)]) begin
                w_found = 1'b1;
                w_pick  = SEL_W'(wrap_idx(int'(r_rr_ptr) + k));
            end
        end
    end

    // Next state plus next values of every registered output and counter.
    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_rr_nxt    = r_rr_ptr;
        w_tmo_nxt   = r_tmo_cnt;
        w_gap_nxt   = r_gap_cnt;
        w_ack_nxt   = '0;
        w_err_nxt   = 1'b0;
        w_rsp_nxt   = r_rsp_data;
        w_wrt_nxt   = 1'b0;
        w_cmd_nxt   = r_spi_cmd;
        w_finish    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_sel_nxt   = w_pick;
                    w_cmd_nxt   = i_cmd[16*int'(w_pick) +: 16];
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                w_wrt_nxt   = 1'b1;
                w_state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_tmo_nxt   = TMO_LOAD;
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                // A done in the terminal-count clk still counts as a normal completion.
                if (i_spi_done || (r_tmo_cnt == '0)) begin
                    w_finish  = 1'b1;
                    w_err_nxt = !i_spi_done;
                    if (i_spi_done) begin
                        w_rsp_nxt = i_spi_rd_data;
                    end
                end else begin
                    w_tmo_nxt = r_tmo_cnt - 1'b1;
                end
            end
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_finish) begin
            w_ack_nxt[r_sel] = 1'b1;
            w_rr_nxt         = (r_sel == SEL_LAST) ? '0 : (r_sel + 1'b1);
            w_gap_nxt        = GAP_LOAD;
            w_state_nxt      = S_GAP;
        end

        // Selects follow the state being entered so they change glitch-free from a flop.
        w_ss_n_nxt = '1;
        if ((w_state_nxt == S_SETUP) || (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_BUSY)) begin
            w_ss_n_nxt[w_sel_nxt] = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath, counters and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel      <= '0;
            r_rr_ptr   <= '0;
            r_tmo_cnt  <= '0;
            r_gap_cnt  <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_rsp_data <= '0;
            r_spi_wrt  <= 1'b0;
            r_spi_cmd  <= '0;
            r_ss_n     <= '1;
        end else begin
            r_sel      <= w_sel_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_tmo_cnt  <= w_tmo_nxt;
            r_gap_cnt  <= w_gap_nxt;
            r_ack      <= w_ack_nxt;
            r_err      <= w_err_nxt;
            r_rsp_data <= w_rsp_nxt;
            r_spi_wrt  <= w_wrt_nxt;
            r_spi_cmd  <= w_cmd_nxt;
            r_ss_n     <= w_ss_n_nxt;
        end
    end

    assign o_ack      = r_ack;
    assign o_err      = r_err;
    assign o_rsp_data = r_rsp_data;
    assign o_spi_wrt  = r_spi_wrt;
    assign o_spi_cmd  = r_spi_cmd;
    assign o_ss_n     = r_ss_n;
    assign o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_bus_arb.sv
// tb_spi_bus_arb: directed bench for spi_bus_arb with a behavioural SPI master.
module tb_spi_bus_arb;

    logic        clk;
    logic        rst;
    logic [4:0]  req;
    logic [79:0] cmd;
    logic [4:0]  ack;
    logic        err;
    logic [15:0] rsp_data;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic [4:0]  ss_n;
    logic        busy;

    int n_asrt = 0;
    int n_fail = 0;

    // SPI master model controls
    int          mdl_dly  = 40;
    bit          mdl_hang = 1'b0;
    logic [15:0] mdl_data = 16'hA5C3;

    spi_bus_arb #(.N_REQ(5), .GAP_CYC(4), .TMO_CYC(1024)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_cmd         (cmd),
        .o_ack         (ack),
        .o_err         (err),
        .o_rsp_data    (rsp_data),
        .o_spi_wrt     (spi_wrt),
        .o_spi_cmd     (spi_cmd),
        .i_spi_done    (spi_done),
        .i_spi_rd_data (spi_rd_data),
        .o_ss_n        (ss_n),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI master: done pulse mdl_dly clks after the wrt pulse, unless hung.
    initial begin
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            if (spi_wrt && !mdl_hang) begin
                repeat (mdl_dly) @(negedge clk);
                spi_done    = 1'b1;
                spi_rd_data = mdl_data;
                @(negedge clk);
                spi_done    = 1'b0;
                spi_rd_data = 16'h0000;
            end
        end
    end

    // At most one slave selected at any time.
    initial begin
        forever begin
            @(negedge clk);
            check("ss_onehot", 32'($countones(~ss_n) <= 1), 32'd1);
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_wrt();
        int c;
        for (c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (spi_wrt) break;
        end
        check("wrt_seen", 32'(c < 3000), 32'd1);
    endtask

    task automatic wait_ack(output int cyc);
        for (cyc = 1; cyc <= 3000; cyc++) begin
            @(negedge clk);
            if (|ack) break;
        end
        check("ack_seen", 32'(cyc <= 3000), 32'd1);
    endtask

    task automatic wait_idle();
        int c;
        for (c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!busy) break;
        end
        check("idle_seen", 32'(c < 3000), 32'd1);
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        req = '0;
        cmd = '0;
        @(negedge clk);
        do_reset();

        // reset state
        check("rst_ss_n", 32'(ss_n), 32'h1f);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rsp", 32'(rsp_data), 32'd0);
        check("rst_cmd", 32'(spi_cmd), 32'd0);
        check("rst_wrt", 32'(spi_wrt), 32'd0);
        repeat (3) @(negedge clk);
        check("noreq_busy", 32'(busy), 32'd0);

        // 1: single trigger-pot write, exact latency
        cmd[63:48] = 16'h1380;
        mdl_dly  = 40;
        mdl_data = 16'hA5C3;
        req = 5'b01000;
        @(negedge clk);
        check("t1_ss_setup", 32'(ss_n), 32'h17);
        check("t1_wrt_setup", 32'(spi_wrt), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_wrt", 32'(spi_wrt), 32'd1);
        check("t1_ss_launch", 32'(ss_n), 32'h17);
        check("t1_cmd", 32'(spi_cmd), 32'h1380);
        wait_ack(cyc);
        check("t1_ack_lat", 32'(cyc), 32'd41);
        check("t1_ack", 32'(ack), 32'h08);
        check("t1_err", 32'(err), 32'd0);
        check("t1_rsp", 32'(rsp_data), 32'hA5C3);
        req = '0;
        for (int g = 0; g < 4; g++) begin
            check("t1_gap_ss", 32'(ss_n), 32'h1f);
            check("t1_gap_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("t1_idle", 32'(busy), 32'd0);

        // 2: all requesting, round-robin from pointer 0
        do_reset();
        for (int i = 0; i < 5; i++) cmd[16*i +: 16] = 16'hC000 + 16'(i);
        mdl_dly = 3;
        req = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            wait_wrt();
            check("t2_cmd", 32'(spi_cmd), 32'hC000 + 32'(k % 5));
            wait_ack(cyc);
            check("t2_ack", 32'(ack), 32'(1) << (k % 5));
            check("t2_err", 32'(err), 32'd0);
        end
        req = '0;
        wait_idle();

        // 3: EEPROM read data returned
        cmd[79:64] = 16'h0300;
        mdl_data = 16'h0034;
        req = 5'b10000;
        wait_ack(cyc);
        check("t3_ack", 32'(ack), 32'h10);
        check("t3_rsp", 32'(rsp_data), 32'h0034);
        check("t3_err", 32'(err), 32'd0);
        req = '0;
        wait_idle();

        // 4: master never completes -> timeout, then normal service
        mdl_hang = 1'b1;
        req = 5'b00010;
        wait_wrt();
        wait_ack(cyc);
        check("t4_tmo_lat", 32'(cyc), 32'd1025);
        check("t4_ack", 32'(ack), 32'h02);
        check("t4_err", 32'(err), 32'd1);
        check("t4_ss_n", 32'(ss_n), 32'h1f);
        check("t4_rsp_kept", 32'(rsp_data), 32'h0034);
        mdl_hang = 1'b0;
        mdl_dly  = 5;
        mdl_data = 16'hBEEF;
        wait_ack(cyc);
        check("t4_next_ack", 32'(ack), 32'h02);
        check("t4_next_err", 32'(err), 32'd0);
        check("t4_next_rsp", 32'(rsp_data), 32'hBEEF);

        // 5: reset in BUSY aborts without ack and clears the pointer
        mdl_hang = 1'b1;
        req = 5'b00100;
        wait_wrt();
        repeat (10) @(negedge clk);
        check("t5_in_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check("t5_ss_n", 32'(ss_n), 32'h1f);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_ack", 32'(ack), 32'd0);
        check("t5_cmd", 32'(spi_cmd), 32'd0);
        rst = 1'b0;
        mdl_hang = 1'b0;
        @(negedge clk);
        check("t5_noack", 32'(ack), 32'd0);
        req = 5'b00110;
        wait_ack(cyc);
        check("t5_first", 32'(ack), 32'h02);
        req = 5'b00100;
        wait_ack(cyc);
        check("t5_second", 32'(ack), 32'h04);
        req = '0;
        wait_idle();

        // 6: done lands in the timeout clk -> normal completion
        mdl_dly  = 1024;
        mdl_data = 16'h1234;
        req = 5'b00001;
        wait_wrt();
        wait_ack(cyc);
        check("t6_lat", 32'(cyc), 32'd1025);
        check("t6_ack", 32'(ack), 32'h01);
        check("t6_err", 32'(err), 32'd0);
        check("t6_rsp", 32'(rsp_data), 32'h1234);
        req = '0;
        wait_idle();
        check("end_ss_n", 32'(ss_n), 32'h1f);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
